// File: rtl/ikbd_host_acia.sv
// ikbd_host_acia
//   Host-side 6850-style ACIA for the keyboard MCU serial link.
//   The frame format is fixed at 8N1, and the bit rate is BAUD_DIV clken ticks per bit.
//   The block presents control, status and data registers on the host bus.
//   It drives a level interrupt.
// Ports
//   CLKx2  : system clock, all state changes on posedge
//   RST_n  : synchronous active-low reset
//   clken  : clock enable, all state/counters advance only when high
//   cs     : register select, high for one clken tick per access
//   rw     : 1=read, 0=write
//   rs     : 0=CR(write)/SR(read), 1=TDR(write)/RDR(read)
//   din    : write data
//   dout   : read data, rs=0 -> SR, rs=1 -> RDR (combinational)
//   irq    : level interrupt request, active high
//   rxd    : asynchronous serial input, idle high
//   txd    : serial output, idle high
module ikbd_host_acia #(
  parameter int BAUD_DIV = 256
) (
  input  logic       CLKx2,
  input  logic       RST_n,
  input  logic       clken,
  input  logic       cs,
  input  logic       rw,
  input  logic       rs,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  input  logic       rxd,
  output logic       txd
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL_END = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // registers
  logic [7:0]    r_cr, r_tdr, r_rdr, r_rx_shift, r_tx_shift;
  logic          r_tdre, r_rdrf, r_fe, r_ovrn, r_rx_prev, r_txd;
  logic [1:0]    r_rx_sync;
  state_t        r_rx_state, r_tx_state;
  logic [CW-1:0] r_rx_cnt, r_tx_cnt;
  logic [2:0]    r_rx_bit, r_tx_bit;

  // next-state values
  logic [7:0]    w_cr_next, w_tdr_next, w_rdr_next, w_rx_shift_next, w_tx_shift_next;
  logic          w_tdre_next, w_rdrf_next, w_fe_next, w_ovrn_next, w_rx_prev_next, w_txd_next;
  logic [1:0]    w_rx_sync_next;
  state_t        w_rx_state_next, w_tx_state_next;
  logic [CW-1:0] w_rx_cnt_next, w_tx_cnt_next;
  logic [2:0]    w_rx_bit_next, w_tx_bit_next;

  logic       w_mr, w_tie, w_irq, w_rx_fall, w_wr_cr, w_wr_tdr, w_rd_rdr;
  logic [7:0] w_sr;

  assign w_mr      = (r_cr[1:0] == 2'b11);
  assign w_tie     = (r_cr[6:5] == 2'b01);
  assign w_irq     = ~w_mr & ((r_cr[7] & (r_rdrf | r_ovrn)) | (w_tie & r_tdre));
  assign w_sr      = {w_irq, 1'b0, r_ovrn, r_fe, 2'b00, r_tdre, r_rdrf};
  assign w_rx_fall = r_rx_prev & ~r_rx_sync[1];
  assign w_wr_cr   = cs & ~rw & ~rs;
  assign w_wr_tdr  = cs & ~rw & rs;
  assign w_rd_rdr  = cs & rw & rs;

  assign dout = rs ? r_rdr : w_sr;
  assign irq  = w_irq;
  assign txd  = r_txd;

  always_comb begin
    w_cr_next       = r_cr;
    w_tdr_next      = r_tdr;
    w_rdr_next      = r_rdr;
    w_rx_shift_next = r_rx_shift;
    w_tx_shift_next = r_tx_shift;
    w_tdre_next     = r_tdre;
    w_rdrf_next     = r_rdrf;
    w_fe_next       = r_fe;
    w_ovrn_next     = r_ovrn;
    w_txd_next      = r_txd;
    w_rx_sync_next  = {r_rx_sync[0], rxd};
    w_rx_prev_next  = r_rx_sync[1];
    w_rx_state_next = r_rx_state;
    w_tx_state_next = r_tx_state;
    w_rx_cnt_next   = r_rx_cnt;
    w_tx_cnt_next   = r_tx_cnt;
    w_rx_bit_next   = r_rx_bit;
    w_tx_bit_next   = r_tx_bit;

    if (w_wr_cr) w_cr_next = din;
    if (w_rd_rdr) begin
      w_rdrf_next = 1'b0;
      w_ovrn_next = 1'b0;
      w_fe_next   = 1'b0;
    end

    // receiver
    unique case (r_rx_state)
      S_IDLE: begin
        if (w_rx_fall) begin
          w_rx_state_next = S_START;
          w_rx_cnt_next   = '0;
        end
      end
      S_START: begin
        w_rx_cnt_next = r_rx_cnt + 1'b1;
        if (r_rx_cnt == HALF_END) begin
          w_rx_cnt_next   = '0;
          w_rx_bit_next   = 3'd0;
          w_rx_state_next = r_rx_sync[1] ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        w_rx_cnt_next = r_rx_cnt + 1'b1;
        if (r_rx_cnt == FULL_END) begin
          w_rx_cnt_next   = '0;
          w_rx_shift_next = {r_rx_sync[1], r_rx_shift[7:1]};
          w_rx_bit_next   = r_rx_bit + 1'b1;
          if (r_rx_bit == 3'd7) w_rx_state_next = S_STOP;
        end
      end
      S_STOP: begin
        w_rx_cnt_next = r_rx_cnt + 1'b1;
        if (r_rx_cnt == FULL_END) begin
          w_rx_cnt_next = '0;
          // a same-tick RDR read frees the buffer, so the new byte lands
          if (!r_rdrf || w_rd_rdr) begin
            w_rdr_next  = r_rx_shift;
            w_rdrf_next = 1'b1;
            w_fe_next   = ~r_rx_sync[1];
          end else begin
            w_ovrn_next = 1'b1;
          end
          w_rx_state_next = w_rx_fall ? S_START : S_IDLE;
        end
      end
      default: w_rx_state_next = S_IDLE;
    endcase

    // transmitter
    unique case (r_tx_state)
      S_IDLE: begin
        if (!r_tdre) begin
          w_txd_next      = 1'b0;
          w_tx_shift_next = r_tdr;
          w_tdre_next     = 1'b1;
          w_tx_cnt_next   = '0;
          w_tx_state_next = S_START;
        end
      end
      S_START: begin
        w_tx_cnt_next = r_tx_cnt + 1'b1;
        if (r_tx_cnt == FULL_END) begin
          w_tx_cnt_next   = '0;
          w_txd_next      = r_tx_shift[0];
          w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
          w_tx_bit_next   = 3'd0;
          w_tx_state_next = S_DATA;
        end
      end
      S_DATA: begin
        w_tx_cnt_next = r_tx_cnt + 1'b1;
        if (r_tx_cnt == FULL_END) begin
          w_tx_cnt_next = '0;
          if (r_tx_bit == 3'd7) begin
            w_txd_next      = 1'b1;
            w_tx_state_next = S_STOP;
          end else begin
            w_txd_next      = r_tx_shift[0];
            w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
            w_tx_bit_next   = r_tx_bit + 1'b1;
          end
        end
      end
      S_STOP: begin
        w_tx_cnt_next = r_tx_cnt + 1'b1;
        if (r_tx_cnt == FULL_END) begin
          w_tx_cnt_next = '0;
          // back-to-back frames: no idle bit between stop and next start
          if (!r_tdre) begin
            w_txd_next      = 1'b0;
            w_tx_shift_next = r_tdr;
            w_tdre_next     = 1'b1;
            w_tx_state_next = S_START;
          end else begin
            w_tx_state_next = S_IDLE;
          end
        end
      end
      default: w_tx_state_next = S_IDLE;
    endcase

    // a TDR write after the FSM's load keeps the newly written byte pending
    if (w_wr_tdr) begin
      w_tdr_next  = din;
      w_tdre_next = 1'b0;
    end

    // master reset holds both FSMs idle and overrides everything above
    if (w_mr) begin
      w_rx_state_next = S_IDLE;
      w_tx_state_next = S_IDLE;
      w_rx_cnt_next   = '0;
      w_tx_cnt_next   = '0;
      w_rx_bit_next   = 3'd0;
      w_tx_bit_next   = 3'd0;
      w_rdrf_next     = 1'b0;
      w_fe_next       = 1'b0;
      w_ovrn_next     = 1'b0;
      w_tdre_next     = 1'b1;
      w_txd_next      = 1'b1;
    end
  end

  always_ff @(posedge CLKx2) begin
    if (!RST_n) begin
      r_cr       <= 8'h03;
      r_tdr      <= 8'h00;
      r_rdr      <= 8'h00;
      r_rx_shift <= 8'h00;
      r_tx_shift <= 8'h00;
      r_tdre     <= 1'b1;
      r_rdrf     <= 1'b0;
      r_fe       <= 1'b0;
      r_ovrn     <= 1'b0;
      r_txd      <= 1'b1;
      r_rx_sync  <= 2'b11;
      r_rx_prev  <= 1'b1;
      r_rx_state <= S_IDLE;
      r_tx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_tx_cnt   <= '0;
      r_rx_bit   <= 3'd0;
      r_tx_bit   <= 3'd0;
    end else if (clken) begin
      r_cr       <= w_cr_next;
      r_tdr      <= w_tdr_next;
      r_rdr      <= w_rdr_next;
      r_rx_shift <= w_rx_shift_next;
      r_tx_shift <= w_tx_shift_next;
      r_tdre     <= w_tdre_next;
      r_rdrf     <= w_rdrf_next;
      r_fe       <= w_fe_next;
      r_ovrn     <= w_ovrn_next;
      r_txd      <= w_txd_next;
      r_rx_sync  <= w_rx_sync_next;
      r_rx_prev  <= w_rx_prev_next;
      r_rx_state <= w_rx_state_next;
      r_tx_state <= w_tx_state_next;
      r_rx_cnt   <= w_rx_cnt_next;
      r_tx_cnt   <= w_tx_cnt_next;
      r_rx_bit   <= w_rx_bit_next;
      r_tx_bit   <= w_tx_bit_next;
    end
  end

endmodule

// File: tb/tb_ikbd_host_acia.sv
// tb_ikbd_host_acia
//   Directed bench for ikbd_host_acia: register access, TX framing, RX framing,
//   overrun, framing error, false start, master-reset abort and IRQ enables.
//   clken is high on every other clock so the enable gating is exercised.
module tb_ikbd_host_acia;

  logic       CLKx2 = 1'b0;
  logic       RST_n = 1'b0;
  logic       clken = 1'b0;
  logic       cs    = 1'b0;
  logic       rw    = 1'b1;
  logic       rs    = 1'b0;
  logic [7:0] din   = 8'h00;
  logic [7:0] dout;
  logic       irq;
  logic       rxd   = 1'b1;
  logic       txd;

  int n_checks = 0;
  int n_pass   = 0;

  ikbd_host_acia #(.BAUD_DIV(256)) dut (
    .CLKx2(CLKx2), .RST_n(RST_n), .clken(clken), .cs(cs), .rw(rw), .rs(rs),
    .din(din), .dout(dout), .irq(irq), .rxd(rxd), .txd(txd)
  );

  always #5 CLKx2 = ~CLKx2;
  always @(negedge CLKx2) clken = ~clken;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-16s got=%02h exp=%02h ok", tag, got, exp);
    end else begin
      $display("FAIL %-16s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  // advance to just after the next clken tick
  task automatic tick();
    @(posedge CLKx2);
    while (!clken) @(posedge CLKx2);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_wr(input logic sel, input logic [7:0] data);
    rs = sel; rw = 1'b0; din = data; cs = 1'b1;
    tick();
    cs = 1'b0; rw = 1'b1;
    $display("bus write rs=%0d data=%02h", sel, data);
  endtask

  task automatic rd_rdr();
    rs = 1'b1; rw = 1'b1; cs = 1'b1;
    tick();
    cs = 1'b0;
    $display("bus read RDR");
  endtask

  task automatic chk_sr(input string tag, input logic [7:0] exp);
    rs = 1'b0; #1;
    chk(tag, dout, exp);
  endtask

  task automatic chk_rdr(input string tag, input logic [7:0] exp);
    rs = 1'b1; #1;
    chk(tag, dout, exp);
    rs = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    $display("rx frame data=%02h stop=%0d", data, stop);
    rxd = 1'b0;
    ticks(256);
    for (int b = 0; b < 8; b++) begin
      rxd = data[b];
      ticks(256);
    end
    rxd = stop;
    ticks(256);
    rxd = 1'b1;
    ticks(4);
  endtask

  logic [7:0] tx_byte;

  initial begin
    ticks(3);
    RST_n = 1'b1;
    tick();

    // reset state
    chk_sr("rst_sr", 8'h02);
    chk("rst_txd", {7'b0, txd}, 8'h01);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk_rdr("rst_rdr", 8'h00);

    // release master reset, RIE on, TIE off
    bus_wr(1'b0, 8'h95);
    tick();
    chk_sr("cr95_sr", 8'h02);
    chk("cr95_irq", {7'b0, irq}, 8'h00);

    // transmit A5
    tx_byte = 8'hA5;
    bus_wr(1'b1, tx_byte);
    chk_sr("tdr_full_sr", 8'h00);
    chk("tx_pre_start", {7'b0, txd}, 8'h01);
    tick();
    chk("tx_start_edge", {7'b0, txd}, 8'h00);
    chk_sr("tx_tdre_set", 8'h02);
    ticks(128);
    chk("tx_start_mid", {7'b0, txd}, 8'h00);
    for (int b = 0; b < 8; b++) begin
      ticks(256);
      chk($sformatf("tx_bit%0d", b), {7'b0, txd}, {7'b0, tx_byte[b]});
    end
    ticks(256);
    chk("tx_stop", {7'b0, txd}, 8'h01);
    ticks(256);
    chk("tx_idle", {7'b0, txd}, 8'h01);

    // receive 3C
    send_frame(8'h3C, 1'b1);
    chk_sr("rx3c_sr", 8'h83);
    chk("rx3c_irq", {7'b0, irq}, 8'h01);
    chk_rdr("rx3c_rdr", 8'h3C);
    rd_rdr();
    chk_sr("rx3c_rd_sr", 8'h02);
    chk("rx3c_rd_irq", {7'b0, irq}, 8'h00);

    // overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    chk_sr("ovrn_sr", 8'hA3);
    chk_rdr("ovrn_rdr", 8'h11);
    rd_rdr();
    chk_sr("ovrn_rd_sr", 8'h02);

    // framing error
    send_frame(8'hEE, 1'b0);
    chk_sr("fe_sr", 8'h93);
    chk_rdr("fe_rdr", 8'hEE);
    rd_rdr();
    chk_sr("fe_rd_sr", 8'h02);

    // false start glitch
    rxd = 1'b0;
    ticks(50);
    rxd = 1'b1;
    ticks(400);
    chk_sr("glitch_sr", 8'h02);
    send_frame(8'h5A, 1'b1);
    chk_sr("after_glitch_sr", 8'h83);
    chk_rdr("after_glitch_rdr", 8'h5A);
    rd_rdr();

    // master reset mid-tx and mid-rx
    bus_wr(1'b1, 8'h00);
    fork
      send_frame(8'h77, 1'b1);
      begin
        ticks(1000);
        chk("mid_tx_low", {7'b0, txd}, 8'h00);
        bus_wr(1'b0, 8'h03);
        ticks(2);
        chk("mr_txd", {7'b0, txd}, 8'h01);
        chk_sr("mr_sr", 8'h02);
      end
    join
    chk_sr("mr_rx_drop_sr", 8'h02);
    chk("mr_idle_txd", {7'b0, txd}, 8'h01);

    // release, RIE off
    bus_wr(1'b0, 8'h15);
    tick();
    send_frame(8'hC3, 1'b1);
    chk_sr("cr15_rx_sr", 8'h03);
    chk("cr15_irq", {7'b0, irq}, 8'h00);
    chk_rdr("cr15_rdr", 8'hC3);

    // TX interrupt enable decode
    bus_wr(1'b0, 8'h35);
    chk("tie_irq", {7'b0, irq}, 8'h01);
    chk_sr("tie_sr", 8'h83);
    bus_wr(1'b0, 8'h55);
    chk("tie10_irq", {7'b0, irq}, 8'h00);
    chk_sr("tie10_sr", 8'h03);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
